// File: rtl/stack_frame_ctrl_pkg.sv
// rtl/stack_frame_ctrl_pkg.sv - shared state encoding and width helpers for the frame stack
package stack_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    CONFIRM = 2'd3
  } state_t;

  function automatic int sel_width(input int frame_words);
    return ($clog2(frame_words) < 1) ? 1 : $clog2(frame_words);
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_frame_ctrl_if.sv
// rtl/stack_frame_ctrl_if.sv - request/response bundle between a frame client and the stack controller
interface stack_frame_ctrl_if #(
  parameter int WIDTH       = 8,
  parameter int FRAME_WORDS = 3,
  parameter int DEPTH       = 48
);
  import stack_frame_ctrl_pkg::*;

  localparam int SELW = sel_width(FRAME_WORDS);
  localparam int LVLW = lvl_width(DEPTH);

  logic                   push_req;
  logic                   pop_req;
  logic [WIDTH-1:0]       push_data;
  logic [SELW-1:0]        src_sel;
  logic [WIDTH-1:0]       pop_data;
  logic [FRAME_WORDS-1:0] field_en;
  logic                   ready;
  logic                   done;
  logic [LVLW-1:0]        level;
  logic                   err_ovf;
  logic                   err_unf;

  modport master (
    output push_req, pop_req, push_data,
    input  src_sel, pop_data, field_en, ready, done, level, err_ovf, err_unf
  );

  modport slave (
    input  push_req, pop_req, push_data,
    output src_sel, pop_data, field_en, ready, done, level, err_ovf, err_unf
  );

endinterface

// File: rtl/stack_frame_ctrl_ram.sv
// rtl/stack_frame_ctrl_ram.sv - word array for the frame stack, synchronous write and asynchronous read
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_frame_ctrl.sv
// rtl/stack_frame_ctrl.sv - moves whole frames on and off a word stack, one word per cycle
module stack_frame_ctrl
  import stack_frame_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FRAME_WORDS = 3,
  parameter int DEPTH       = 48
) (
  input  logic              clk,
  input  logic              rst,
  stack_frame_ctrl_if.slave bus
);

  localparam int SELW = sel_width(FRAME_WORDS);
  localparam int LVLW = lvl_width(DEPTH);
  localparam int AW   = addr_width(DEPTH);

  localparam logic [LVLW-1:0] FW_L   = LVLW'(FRAME_WORDS);
  localparam logic [LVLW-1:0] ROOM_L = LVLW'(DEPTH - FRAME_WORDS);
  localparam logic [SELW-1:0] K_LAST = SELW'(FRAME_WORDS - 1);

  state_t                 state, state_next;
  logic [SELW-1:0]        k, k_next;
  logic [LVLW-1:0]        level, level_next;
  logic                   err_ovf, err_ovf_next;
  logic                   err_unf, err_unf_next;

  logic                   we;
  logic [AW-1:0]          raddr;
  logic [WIDTH-1:0]       rdata;
  logic [SELW-1:0]        src_sel;
  logic [WIDTH-1:0]       pop_data;
  logic [FRAME_WORDS-1:0] field_en;
  logic                   ready;
  logic                   done;

  // Top of stack sits at level-1; only read while POP guarantees level>=1.
  assign raddr = AW'(level - LVLW'(1));

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(AW'(level)),
    .wdata(bus.push_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      level   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      state   <= state_next;
      k       <= k_next;
      level   <= level_next;
      err_ovf <= err_ovf_next;
      err_unf <= err_unf_next;
    end
  end

  always_comb begin
    state_next   = state;
    k_next       = k;
    level_next   = level;
    err_ovf_next = err_ovf;
    err_unf_next = err_unf;
    we           = 1'b0;
    src_sel      = '0;
    pop_data     = '0;
    field_en     = '0;
    ready        = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        // Pop wins when both requests arrive together.
        if (bus.pop_req) begin
          if (level >= FW_L) begin
            state_next = POP;
            k_next     = K_LAST;
          end else begin
            state_next   = CONFIRM;
            err_unf_next = 1'b1;
          end
        end else if (bus.push_req) begin
          if (level <= ROOM_L) begin
            state_next = PUSH;
            k_next     = '0;
          end else begin
            state_next   = CONFIRM;
            err_ovf_next = 1'b1;
          end
        end
      end

      PUSH: begin
        src_sel    = k;
        we         = 1'b1;
        level_next = level + LVLW'(1);
        if (k == K_LAST) begin
          state_next = CONFIRM;
          k_next     = '0;
        end else begin
          k_next = k + SELW'(1);
        end
      end

      POP: begin
        pop_data   = rdata;
        field_en   = FRAME_WORDS'(1) << k;
        level_next = level - LVLW'(1);
        if (k == '0) begin
          state_next = CONFIRM;
        end else begin
          k_next = k - SELW'(1);
        end
      end

      CONFIRM: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.src_sel  = src_sel;
  assign bus.pop_data = pop_data;
  assign bus.field_en = field_en;
  assign bus.ready    = ready;
  assign bus.done     = done;
  assign bus.level    = level;
  assign bus.err_ovf  = err_ovf;
  assign bus.err_unf  = err_unf;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// tb/tb_stack_frame_ctrl.sv - randomized frame push/pop against an array stack model, two parameter sets
module tb_stack_frame_ctrl;
  import stack_frame_ctrl_pkg::*;

  localparam int DEPTH = 48;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  int which = 0;
  int fw    = 3;
  int frame [8];
  int mem_m [2][DEPTH];
  int lvl_m [2];
  bit ovf_m [2];
  bit unf_m [2];

  logic [31:0] o_src, o_pop, o_fen, o_lvl;
  logic        o_ready, o_done, o_ovf, o_unf;

  always #5 clk = ~clk;

  stack_frame_ctrl_if #(.WIDTH(8),  .FRAME_WORDS(3), .DEPTH(DEPTH)) bus_a ();
  stack_frame_ctrl_if #(.WIDTH(16), .FRAME_WORDS(1), .DEPTH(DEPTH)) bus_b ();

  stack_frame_ctrl #(.WIDTH(8), .FRAME_WORDS(3), .DEPTH(DEPTH)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  stack_frame_ctrl #(.WIDTH(16), .FRAME_WORDS(1), .DEPTH(DEPTH)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  // External source mux: the controller picks the field, the client supplies it.
  always_comb begin
    bus_a.push_data = 8'(frame[bus_a.src_sel]);
    bus_b.push_data = 16'(frame[bus_b.src_sel]);
  end

  always_comb begin
    if (which == 0) begin
      o_src   = 32'(bus_a.src_sel);
      o_pop   = 32'(bus_a.pop_data);
      o_fen   = 32'(bus_a.field_en);
      o_lvl   = 32'(bus_a.level);
      o_ready = bus_a.ready;
      o_done  = bus_a.done;
      o_ovf   = bus_a.err_ovf;
      o_unf   = bus_a.err_unf;
    end else begin
      o_src   = 32'(bus_b.src_sel);
      o_pop   = 32'(bus_b.pop_data);
      o_fen   = 32'(bus_b.field_en);
      o_lvl   = 32'(bus_b.level);
      o_ready = bus_b.ready;
      o_done  = bus_b.done;
      o_ovf   = bus_b.err_ovf;
      o_unf   = bus_b.err_unf;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s (inst %0d): got %0d expected %0d", tag, which, obs, exp);
    end
  endtask

  task automatic set_req(input bit p, input bit q);
    bus_a.push_req = (which == 0) && p;
    bus_a.pop_req  = (which == 0) && q;
    bus_b.push_req = (which == 1) && p;
    bus_b.pop_req  = (which == 1) && q;
  endtask

  task automatic fill_frame();
    int mask;
    mask = (which == 1) ? 32'hffff : 32'hff;
    for (int i = 0; i < 8; i++) frame[i] = int'($urandom) & mask;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sel"}, o_src, 0);
    check({tag, "_pop"}, o_pop, 0);
    check({tag, "_fen"}, o_fen, 0);
  endtask

  // kind: 0 idle, 1 push, 2 pop, 3 overflow reject, 4 underflow reject
  task automatic do_op(input bit p, input bit q, input bit hold);
    int l0;
    int kind;
    l0 = lvl_m[which];
    if (q)      kind = (l0 >= fw) ? 2 : 4;
    else if (p) kind = (l0 + fw <= DEPTH) ? 1 : 3;
    else        kind = 0;

    check("ready_before", 32'(o_ready), 1);
    set_req(p, q);
    @(negedge clk);
    if (!hold) set_req(0, 0);

    case (kind)
      0: begin
        check("idle_lvl", o_lvl, 32'(l0));
        check("idle_rdy", 32'(o_ready), 1);
      end
      1: begin
        for (int i = 0; i < fw; i++) begin
          if (i > 0) begin
            @(negedge clk);
            set_req(0, 0);
          end
          check("push_sel", o_src, 32'(i));
          check("push_lvl", o_lvl, 32'(l0 + i));
          check("push_fen", o_fen, 0);
          check("push_pop", o_pop, 0);
          check("push_rdy", 32'(o_ready), 0);
          mem_m[which][l0 + i] = frame[i];
        end
        lvl_m[which] = l0 + fw;
      end
      2: begin
        for (int i = 0; i < fw; i++) begin
          if (i > 0) begin
            @(negedge clk);
            set_req(0, 0);
          end
          check("pop_fen",  o_fen, 32'(1 << (fw - 1 - i)));
          check("pop_data", o_pop, 32'(mem_m[which][l0 - 1 - i]));
          check("pop_lvl",  o_lvl, 32'(l0 - i));
          check("pop_sel",  o_src, 0);
          check("pop_done", 32'(o_done), 0);
        end
        lvl_m[which] = l0 - fw;
      end
      3: ovf_m[which] = 1'b1;
      4: unf_m[which] = 1'b1;
      default: ;
    endcase

    if (kind != 0) begin
      if (kind == 1 || kind == 2) begin
        @(negedge clk);
        set_req(0, 0);
      end
      check("confirm_done", 32'(o_done), 1);
      check("confirm_lvl",  o_lvl, 32'(lvl_m[which]));
      check("confirm_rdy",  32'(o_ready), 0);
      check_quiet("confirm");
      @(negedge clk);
      set_req(0, 0);
      check("back_rdy",  32'(o_ready), 1);
      check("back_done", 32'(o_done), 0);
    end
    check("err_ovf", 32'(o_ovf), 32'(ovf_m[which]));
    check("err_unf", 32'(o_unf), 32'(unf_m[which]));
  endtask

  task automatic rand_op();
    int r;
    bit hold;
    r    = $urandom_range(0, 9);
    hold = 1'($urandom_range(0, 1));
    fill_frame();
    if (r == 0)      do_op(0, 0, hold);
    else if (r <= 5) do_op(1, 0, hold);
    else if (r <= 8) do_op(0, 1, hold);
    else             do_op(1, 1, hold);
  endtask

  // Abort a push part-way through; the shared reset also clears the other instance.
  task automatic reset_mid();
    fill_frame();
    set_req(1, 0);
    @(negedge clk);
    set_req(0, 0);
    if (fw > 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_lvl",  o_lvl, 0);
    check("rst_done", 32'(o_done), 0);
    check_quiet("rst");
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      lvl_m[j] = 0;
      ovf_m[j] = 1'b0;
      unf_m[j] = 1'b0;
    end
    #1;
    check("rst_rdy", 32'(o_ready), 1);
    check("rst_lvl_after", o_lvl, 0);
    check("rst_ovf", 32'(o_ovf), 0);
    check("rst_unf", 32'(o_unf), 0);
  endtask

  initial begin
    rst = 1'b1;
    which = 0;
    fw = 3;
    set_req(0, 0);
    for (int i = 0; i < 8; i++) frame[i] = 0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      which = j;
      #1;
      check("reset_lvl",  o_lvl, 0);
      check("reset_done", 32'(o_done), 0);
      check("reset_ovf",  32'(o_ovf), 0);
      check("reset_unf",  32'(o_unf), 0);
      check_quiet("reset");
    end
    which = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rdy", 32'(o_ready), 1);
    @(negedge clk);

    frame[0] = 5; frame[1] = 8; frame[2] = 13;
    do_op(1, 0, 0);
    check("first_push_lvl", o_lvl, 3);
    do_op(0, 1, 0);
    check("first_pop_lvl", o_lvl, 0);

    repeat (16) begin
      fill_frame();
      do_op(1, 0, 0);
    end
    check("full_lvl", o_lvl, 48);
    fill_frame();
    do_op(1, 0, 0);
    check("ovf_flag", 32'(o_ovf), 1);
    check("ovf_lvl",  o_lvl, 48);
    do_op(0, 1, 0);
    check("after_ovf_lvl", o_lvl, 45);

    repeat (15) do_op(0, 1, 0);
    do_op(0, 1, 0);
    check("unf_flag", 32'(o_unf), 1);
    check("unf_lvl",  o_lvl, 0);

    fill_frame();
    do_op(1, 0, 0);
    do_op(1, 1, 0);
    check("both_lvl", o_lvl, 0);

    reset_mid();
    frame[0] = 1; frame[1] = 2; frame[2] = 3;
    do_op(1, 0, 0);
    do_op(0, 1, 0);

    repeat (150) rand_op();

    which = 1;
    fw = 1;
    #1;
    reset_mid();
    for (int v = 1; v <= 3; v++) begin
      frame[0] = v;
      do_op(1, 0, 0);
    end
    repeat (3) do_op(0, 1, 0);
    check("b_empty_lvl", o_lvl, 0);

    repeat (150) rand_op();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
